fixed_point_mac: RTL

Parametrised, pipelined signed fixed-point multiply-accumulate unit for the MLP neuron datapath. It accepts a stream of (input, weight) pairs over a valid/ready handshake and forms the exact full-width product of each pair. It sums the products of one vector in a wide accumulator. On the last term it emits one result, rescaled to the input Q-format and saturated. It replaces the single combinational multiplier feeding each neuron's dot product and sits between the weight/activation fetch logic and the activation-function stage.

---
 rtl/fixed_point_mac.sv | 73 +++++++
 1 files changed

// File: rtl/fixed_point_mac.sv
// fixed_point_mac: pipelined signed fixed-point MAC with rescale and saturation; define ROUND_NEAREST_EN for round-half-up rescale.
module fixed_point_mac #(
  parameter int BITS      = 16,
  parameter int FRAC_BITS = 11,
  parameter int ACC_BITS  = 40
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [BITS-1:0] a,
  input  logic signed [BITS-1:0] b,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [BITS-1:0] result,
  output logic                   overflow
);
  localparam logic signed [ACC_BITS-1:0] SAT_MAX = {{(ACC_BITS-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] SAT_MIN = {{(ACC_BITS-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
`ifdef ROUND_NEAREST_EN
  localparam logic signed [ACC_BITS-1:0] HALF = ACC_BITS'(1) << (FRAC_BITS-1);
`endif
  logic signed [2*BITS-1:0] p_q, p_d;
  logic signed [ACC_BITS-1:0] acc_q, acc_d, sum, t;
  logic signed [BITS-1:0] result_q, result_d;
  logic p_valid_q, p_valid_d, p_last_q, p_last_d;
  logic out_valid_q, out_valid_d, overflow_q, overflow_d;
  logic stall, accept, emit, hi, lo;
  always_comb begin
    stall = out_valid_q && !out_ready;
    accept = p_valid_q && !stall;
    emit = accept && p_last_q;
    sum = acc_q + ACC_BITS'(p_q);
`ifdef ROUND_NEAREST_EN
    t = (sum + HALF) >>> FRAC_BITS;
`else
    t = sum >>> FRAC_BITS;
`endif
    hi = t > SAT_MAX;
    lo = t < SAT_MIN;
    p_d = (in_valid && !stall) ? (2*BITS)'(a) * (2*BITS)'(b) : p_q;
    p_valid_d = stall ? p_valid_q : in_valid;
    p_last_d = stall ? p_last_q : in_last;
    acc_d = accept ? (p_last_q ? '0 : sum) : acc_q;
    out_valid_d = emit || stall;
    result_d = emit ? (hi ? SAT_MAX[BITS-1:0] : lo ? SAT_MIN[BITS-1:0] : t[BITS-1:0]) : result_q;
    overflow_d = emit ? (hi || lo) : overflow_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= '0;
      p_valid_q <= 1'b0;
      p_last_q <= 1'b0;
      acc_q <= '0;
      out_valid_q <= 1'b0;
      result_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      p_q <= p_d;
      p_valid_q <= p_valid_d;
      p_last_q <= p_last_d;
      acc_q <= acc_d;
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      overflow_q <= overflow_d;
    end
  end
  assign in_ready = !stall;
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign overflow = overflow_q;
endmodule
